// File: rtl/wb_stage_arb.sv
// Writeback stage: registers the result and arbitrates the register-file write port
// between the in-order pipeline and a FIFO-buffered long-latency channel.
// Optional load lane extraction and sign extension is enabled by defining WB_LOAD_EXT_EN.
module wb_stage_arb #(
  parameter int XLEN       = 32,
  parameter int REGW       = 5,
  parameter int LL_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pipe_valid,
  input  logic            pipe_regw_en,
  input  logic            pipe_sys_en,
  input  logic [REGW-1:0] pipe_rd,
  input  logic [XLEN-1:0] pipe_alu_result,
  input  logic [XLEN-1:0] pipe_mem_data,
  input  logic            pipe_mem_to_reg,
  input  logic [1:0]      pipe_ld_size,
  input  logic            pipe_ld_unsigned,
  input  logic [1:0]      pipe_addr_lo,
  input  logic            ll_valid,
  output logic            ll_ready,
  input  logic [REGW-1:0] ll_rd,
  input  logic [XLEN-1:0] ll_data,
  output logic [XLEN-1:0] WriteData,
  output logic [REGW-1:0] RegD,
  output logic            RegW_en,
  output logic            RegW_en_System,
  output logic            wb_hold,
  output logic            wb_err
);

  localparam int PW = (LL_DEPTH > 1) ? $clog2(LL_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            hold_q, hold_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [REGW-1:0] reg_d_q, reg_d_d;
  logic            regw_en_q, regw_en_d;
  logic            regw_sys_q, regw_sys_d;

  logic [REGW-1:0] fifo_rd_mem   [LL_DEPTH];
  logic [XLEN-1:0] fifo_data_mem [LL_DEPTH];

  logic            fifo_empty;
  logic            push_accept;
  logic            push_store;
  logic            pipe_req;
  logic            pipe_win;
  logic            pop;
  logic [XLEN-1:0] load_data;

  assign fifo_empty  = (count_q == '0);
  assign ll_ready    = (count_q != CW'(LL_DEPTH));
  assign push_accept = ll_valid && ll_ready;
  // Writes to x0 are acknowledged to the producer but never occupy a slot.
  assign push_store  = push_accept && (ll_rd != '0);
  assign pipe_req    = pipe_valid && (pipe_regw_en || pipe_sys_en);
  assign pipe_win    = pipe_req && !hold_q;
  assign pop         = !pipe_win && !fifo_empty;

`ifdef WB_LOAD_EXT_EN
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        unused_ld_hi;

  assign unused_ld_hi = ^pipe_mem_data[XLEN-1:XLEN-1];

  always_comb begin
    ld_byte = pipe_mem_data[7:0];
    case (pipe_addr_lo)
      2'd1:    ld_byte = pipe_mem_data[15:8];
      2'd2:    ld_byte = pipe_mem_data[23:16];
      2'd3:    ld_byte = pipe_mem_data[31:24];
      default: ld_byte = pipe_mem_data[7:0];
    endcase
    ld_half = pipe_addr_lo[1] ? pipe_mem_data[31:16] : pipe_mem_data[15:0];
    case (pipe_ld_size)
      2'b00:   load_data = {{(XLEN-8){ld_byte[7] & ~pipe_ld_unsigned}}, ld_byte};
      2'b01:   load_data = {{(XLEN-16){ld_half[15] & ~pipe_ld_unsigned}}, ld_half};
      default: load_data = pipe_mem_data;
    endcase
  end
`else
  logic unused_ld_ctrl;

  assign unused_ld_ctrl = ^{pipe_ld_size, pipe_ld_unsigned, pipe_addr_lo};
  assign load_data      = pipe_mem_data;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_store) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)        rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_store, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // The counter only advances while the head is waiting behind pipeline traffic.
  always_comb begin
    starve_d = starve_q;
    hold_d   = 1'b0;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (pipe_win) begin
      if (starve_q == SW'(STARVE_MAX - 1)) begin
        starve_d = '0;
        hold_d   = 1'b1;
      end else begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  always_comb begin
    write_data_d = write_data_q;
    reg_d_d      = reg_d_q;
    regw_en_d    = 1'b0;
    regw_sys_d   = 1'b0;
    err_d        = err_q || (pipe_req && hold_q);
    if (pipe_win) begin
      reg_d_d      = pipe_rd;
      write_data_d = pipe_mem_to_reg ? load_data : pipe_alu_result;
      regw_en_d    = pipe_regw_en && (pipe_rd != '0);
      regw_sys_d   = pipe_sys_en;
    end else if (pop) begin
      reg_d_d      = fifo_rd_mem[rd_ptr_q];
      write_data_d = fifo_data_mem[rd_ptr_q];
      regw_en_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_store) begin
      fifo_rd_mem[wr_ptr_q]   <= ll_rd;
      fifo_data_mem[wr_ptr_q] <= ll_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      hold_q       <= 1'b0;
      err_q        <= 1'b0;
      write_data_q <= '0;
      reg_d_q      <= '0;
      regw_en_q    <= 1'b0;
      regw_sys_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      hold_q       <= hold_d;
      err_q        <= err_d;
      write_data_q <= write_data_d;
      reg_d_q      <= reg_d_d;
      regw_en_q    <= regw_en_d;
      regw_sys_q   <= regw_sys_d;
    end
  end

  assign WriteData      = write_data_q;
  assign RegD           = reg_d_q;
  assign RegW_en        = regw_en_q;
  assign RegW_en_System = regw_sys_q;
  assign wb_hold        = hold_q;
  assign wb_err         = err_q;

endmodule

// File: doc/wb_stage_arb.md
Name: wb_stage_arb

Overview:
- Parametrised successor of the single-source writeback stage.
- Registers the writeback result and shares one register-file write port between two sources:
  - the in-order pipeline result: ALU or load data, selected by MemToReg;
  - a long-latency result channel (mul/div/system) with valid/ready handshake, buffered in a small FIFO.
- Pipeline has priority. An anti-starvation counter forces the buffered results out.
- Sits between MEM stage / long-latency units and the register file.

Parameters:
XLEN, 32, data width of results and WriteData
REGW, 5, register index width
LL_DEPTH, 4, long-latency FIFO entries (power of 2, >=2)
STARVE_MAX, 8, consecutive cycles a non-empty FIFO head may lose before hold is raised (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
pipe_valid  in  1  pipeline result present this cycle
pipe_regw_en  in  1  pipeline register write request
pipe_sys_en  in  1  pipeline system-register write request
pipe_rd  in  REGW  pipeline destination
pipe_alu_result  in  XLEN  ALU result
pipe_mem_data  in  XLEN  raw memory read word
pipe_mem_to_reg  in  1  1 = load data, 0 = ALU result
pipe_ld_size  in  2  00 byte, 01 half, 10 word
pipe_ld_unsigned  in  1  zero-extend load
pipe_addr_lo  in  2  load address bits [1:0]
ll_valid  in  1  long-latency result offered
ll_ready  out  1  FIFO accepts; equals !full (from registered count)
ll_rd  in  REGW  long-latency destination
ll_data  in  XLEN  long-latency result
WriteData  out  XLEN  registered write data
RegD  out  REGW  registered destination
RegW_en  out  1  registered GPR write enable
RegW_en_System  out  1  registered system write enable
wb_hold  out  1  registered; upstream must not assert pipe_valid next cycle
wb_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (reset=0, async): WriteData=0, RegD=0, RegW_en=0, RegW_en_System=0, wb_hold=0, wb_err=0, FIFO empty, starve counter 0. ll_ready=1 once reset is released.
- Latency: exactly 1 cycle from input to outputs; outputs are flops.
- Enqueue: push when ll_valid && ll_ready.
  - ll_rd==0 is accepted but dropped, not stored.
  - When full, ll_ready=0 even if a pop happens the same cycle.
- Per-cycle arbitration:
  - P = pipe_valid && (pipe_regw_en || pipe_sys_en).
  - If P && !wb_hold: pipeline wins. Next RegD=pipe_rd, RegW_en=pipe_regw_en && (pipe_rd!=0), RegW_en_System=pipe_sys_en. WriteData = load data when pipe_mem_to_reg, else pipe_alu_result.
  - Else if FIFO non-empty: pop head. Next RegD=head rd, WriteData=head data, RegW_en=1, RegW_en_System=0.
  - Else: RegW_en=0, RegW_en_System=0. WriteData/RegD hold their previous value.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the pipeline wins.
  - Clears on any pop or when the FIFO is empty.
  - On reaching STARVE_MAX, wb_hold=1 for the next cycle and the counter clears.
  - Under hold, the head pops; wb_hold drops after that one cycle.
- Protocol violation: P while wb_hold=1 sets wb_err (sticky until reset). The pipeline result is lost and the FIFO head pops.
- pipe_valid=0 ignores all pipe_* inputs.
- RAW ordering between pipeline and long-latency writes to the same rd is out of scope; the upstream scoreboard owns it.
- Reset mid-operation discards FIFO contents and any pending hold.

Optional Feature:
- Macro: WB_LOAD_EXT_EN.
- Defined:
  - Load data is lane-extracted from pipe_mem_data. Byte lane = pipe_addr_lo; half lane = pipe_addr_lo[1].
  - Sign-extended unless pipe_ld_unsigned. Word passes raw.
  - Misaligned half/word uses the lane bits as given, with no trap.
- Undefined: load data = pipe_mem_data raw; pipe_ld_size, pipe_ld_unsigned and pipe_addr_lo are ignored.

Test Plan:
- Reset low mid-traffic, then released -> all outputs 0, ll_ready=1 next cycle, FIFO empty.
- pipe_valid=1, regw_en=1, rd=5, mem_to_reg=0, alu=0x1234 -> next cycle RegW_en=1, RegD=5, WriteData=0x00001234. Same with rd=0 -> RegW_en=0.
- WB_LOAD_EXT_EN, mem_data=0x80FF7F01:
  - byte, addr_lo=3, signed -> 0xFFFFFF80;
  - half, addr_lo=2, unsigned -> 0x000080FF;
  - word -> 0x80FF7F01.
- Push 4 ll results (rd=1..4) while pipe is idle -> written in order 1,2,3,4 on consecutive cycles. With 4 pushes and continuous pipe traffic, ll_ready=0 on the fifth offer.
- Continuous pipe traffic with FIFO non-empty, STARVE_MAX=8 -> wb_hold=1 after 8 lost cycles. Next cycle pops rd=1 with RegW_en=1 and RegW_en_System=0.
- pipe_valid with regw_en=1 while wb_hold=1 -> wb_err=1 and stays set until reset.
